// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for the BCD countdown timer.
// The master drives the controls and observes the count and status flags.
interface bcd_countdown_timer_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    start;
  logic                    pause;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    running;
  logic                    done;
  logic                    expired;

  modport master (
    output clear, load, load_value, start, pause,
    input  count, running, done, expired
  );

  modport slave (
    input  clear, load, load_value, start, pause,
    output count, running, done, expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with a tick prescaler and load/start/pause/clear control.
// Optional macro TIMER_AUTO_RELOAD_EN: reload from the last loaded value on expiry and keep running.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | loaded or cleared, waiting for start
// S_RUN    | prescaler advancing, count decrements on each tick
// S_PAUSED | count and prescaler frozen, start resumes
// S_DONE   | count reached zero, held until clear, load or reset
module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1
) (
  input logic                  clk,
  input logic                  reset,
  bcd_countdown_timer_if.slave tmr
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          expired_q, expired_d;
  logic          running_q, done_q;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [W-1:0]  shadow_q, shadow_d;
`endif

  logic [W-1:0]  load_clamped;
  logic [W-1:0]  count_dec;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple borrow: a digit only borrows when every lower digit was zero.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_clamped = bcd_clamp(tmr.load_value);
  assign count_dec    = bcd_dec(count_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    shadow_d  = shadow_q;
`endif
    if (tmr.clear) begin
      state_d  = S_IDLE;
      count_d  = '0;
      presc_d  = '0;
`ifdef TIMER_AUTO_RELOAD_EN
      shadow_d = '0;
`endif
    end else if (tmr.load && (state_q != S_RUN)) begin
      state_d  = S_IDLE;
      count_d  = load_clamped;
      presc_d  = '0;
`ifdef TIMER_AUTO_RELOAD_EN
      shadow_d = load_clamped;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_PAUSED: begin
          // pause has precedence over start when both are asserted
          if (tmr.start && !tmr.pause) begin
            if (count_q != '0) begin
              state_d = S_RUN;
              if (state_q == S_IDLE) presc_d = '0;
            end else begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (tmr.pause) begin
            state_d = S_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
`ifdef TIMER_AUTO_RELOAD_EN
            if (count_q == '0) begin
              count_d = shadow_q;
              if (shadow_q == '0) state_d = S_DONE;
            end else begin
              count_d = count_dec;
              if (count_dec == '0) begin
                expired_d = 1'b1;
                if (shadow_q == '0) state_d = S_DONE;
              end
            end
`else
            count_d = count_dec;
            if (count_dec == '0) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end
`endif
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      shadow_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
`ifdef TIMER_AUTO_RELOAD_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  assign tmr.count   = count_q;
  assign tmr.running = running_q;
  assign tmr.done    = done_q;
  assign tmr.expired = expired_q;

endmodule
